// File: rtl/ad5676r_multi_writer.sv
// ad5676r_multi_writer
// Buffers host write commands in a small FIFO and serialises each one as a
// 24-bit AD5676R frame: SYNC low, 24 SCLK falling edges, MSB first.
//
// Optional feature: define DAC_LDAC_PULSE_EN to add da_ldac_inv and an LDAC
// state. After a code 4'h1 frame, if no further work is queued, LDAC is
// pulsed low for 2*SCLK_DIV cycles.
//
// Parameters:
//   NUM_CH      number of addressable DAC channels (1..8)
//   SCLK_DIV    da_sclk half-period in clk cycles (>=1)
//   FIFO_DEPTH  command FIFO entries (power of 2, >=2)
//   SYNC_GAP    clk cycles spent in GAP after each frame (>=1)
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   cmd_valid / cmd_ready     command handshake (ready = FIFO not full)
//   cmd_code/addr/data        command nibble, channel address, 16-bit code
//   err_addr                  one-cycle pulse when a bad address is rejected
//   busy                      FIFO non-empty or frame in progress
//   da_sclk, da_sdin          serial clock (idles high) and data
//   da_sync_inv               active-low frame sync
//   da_ldac_inv               active-low LDAC (only with DAC_LDAC_PULSE_EN)

module ad5676r_multi_writer #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SYNC_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_code,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        err_addr,
    output logic        busy,
    output logic        da_sclk,
    output logic        da_sdin,
`ifdef DAC_LDAC_PULSE_EN
    output logic        da_ldac_inv,
`endif
    output logic        da_sync_inv
);

    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = AW + 1;

    localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(SYNC_GAP - 1);
`ifdef DAC_LDAC_PULSE_EN
    localparam logic [15:0] LDAC_LAST = 16'(2 * SCLK_DIV - 1);
`endif

`ifdef DAC_LDAC_PULSE_EN
    typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap, StLdac} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap} state_e;
`endif

    state_e state_q, state_d;

    // ---------------- command FIFO ----------------
    logic [23:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full, fifo_empty, addr_ok, push, pop;
    logic [23:0]      fifo_head;
    logic             err_q;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign addr_ok    = ({28'd0, cmd_addr} < NUM_CH);
    assign push       = cmd_valid && cmd_ready && addr_ok;
    // LOAD is only entered with the FIFO non-empty, so it always pops.
    assign pop        = (state_q == StLoad);
    assign fifo_head  = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd_code, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= cmd_valid && cmd_ready && !addr_ok;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // ---------------- datapath: counters and shifter ----------------
    logic [15:0] cnt_q;     // cycles in state; in SHIFT, cycles within a half-period
    logic [5:0]  phase_q;   // SCLK half-period index 0..47 during SHIFT
    logic [23:0] sreg_q;
`ifdef DAC_LDAC_PULSE_EN
    logic [3:0]  last_code_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
            sreg_q  <= '0;
`ifdef DAC_LDAC_PULSE_EN
            last_code_q <= '0;
`endif
        end else begin
            if (state_d != state_q || (state_q == StShift && cnt_q == DIV_LAST)) begin
                cnt_q <= '0;
            end else if (state_q != StIdle) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == StLoad) begin
                sreg_q  <= fifo_head;
                phase_q <= '0;
`ifdef DAC_LDAC_PULSE_EN
                last_code_q <= fifo_head[23:20];
`endif
            end else if (state_q == StShift && cnt_q == DIV_LAST) begin
                phase_q <= phase_q + 1'b1;
                // End of a low half-period: SCLK rises, present the next bit.
                if (phase_q[0]) sreg_q <= {sreg_q[22:0], 1'b0};
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!fifo_empty) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (phase_q == 6'd47 && cnt_q == DIV_LAST) state_d = StGap;
            StGap: begin
                if (cnt_q == GAP_LAST) begin
`ifdef DAC_LDAC_PULSE_EN
                    if (last_code_q == 4'h1 && fifo_empty) state_d = StLdac;
                    else                                   state_d = StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef DAC_LDAC_PULSE_EN
            StLdac:  if (cnt_q == LDAC_LAST) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded from registered state so reset forces idle levels at once.
    always_comb begin
        da_sync_inv = 1'b1;
        da_sclk     = 1'b1;
        da_sdin     = 1'b0;
        if (state_q == StShift) begin
            da_sync_inv = 1'b0;
            da_sclk     = ~phase_q[0];
            da_sdin     = sreg_q[23];
        end
`ifdef DAC_LDAC_PULSE_EN
        da_ldac_inv = (state_q != StLdac);
`endif
    end

    assign busy     = (state_q != StIdle) || !fifo_empty;
    assign err_addr = err_q;

endmodule

// File: tb/tb_ad5676r_multi_writer.sv
module tb_ad5676r_multi_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-channel instance
    logic        valid = 1'b0;
    logic [3:0]  code = '0, addr = '0;
    logic [15:0] data = '0;
    logic        ready, err, busy, sclk, sdin, sync;
`ifdef DAC_LDAC_PULSE_EN
    logic        ldac;
`endif

    // 4-channel instance for address rejection
    logic        v4 = 1'b0;
    logic [3:0]  code4 = '0, addr4 = '0;
    logic [15:0] data4 = '0;
    logic        ready4, err4, busy4, sclk4, sdin4, sync4;
`ifdef DAC_LDAC_PULSE_EN
    logic        ldac4;
`endif

    ad5676r_multi_writer #(.NUM_CH(8), .SCLK_DIV(2), .FIFO_DEPTH(4), .SYNC_GAP(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(valid), .cmd_ready(ready),
        .cmd_code(code), .cmd_addr(addr), .cmd_data(data),
        .err_addr(err), .busy(busy), .da_sclk(sclk), .da_sdin(sdin),
`ifdef DAC_LDAC_PULSE_EN
        .da_ldac_inv(ldac),
`endif
        .da_sync_inv(sync)
    );

    ad5676r_multi_writer #(.NUM_CH(4), .SCLK_DIV(2), .FIFO_DEPTH(4), .SYNC_GAP(2)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(ready4),
        .cmd_code(code4), .cmd_addr(addr4), .cmd_data(data4),
        .err_addr(err4), .busy(busy4), .da_sclk(sclk4), .da_sdin(sdin4),
`ifdef DAC_LDAC_PULSE_EN
        .da_ldac_inv(ldac4),
`endif
        .da_sync_inv(sync4)
    );

    int tests = 0;
    int fails = 0;

    logic [23:0] words [5] = '{24'h301234, 24'h315678, 24'h329ABC, 24'h37DEF0, 24'h340F0F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called while sync is observed low; returns at the first high sample.
    task automatic capture(output logic [23:0] w, output int low, output int falls);
        logic prev;
        w = '0; low = 1; falls = 0; prev = sclk;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (sync) break;
            low++;
            if (prev && !sclk) begin
                w = {w[22:0], sdin};
                falls++;
            end
            prev = sclk;
        end
    endtask

    // Counts high samples until sync goes low; 9999 on timeout.
    task automatic wait_low(output int highs);
        highs = 0;
        for (int i = 0; i < 500 && sync; i++) begin
            step();
            highs++;
        end
        if (sync) highs = 9999;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy; i++) step();
        chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        logic [23:0] w;
        int l, fl, h, bad;

        // ---- reset state ----
        step(); step();
        chk("rst_sclk", 32'(sclk), 1);
        chk("rst_sdin", 32'(sdin), 0);
        chk("rst_sync", 32'(sync), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(ready), 1);

        // ---- single frame: code 3 / addr 2 / ABCD ----
        code = 4'h3; addr = 4'h2; data = 16'hABCD; valid = 1'b1;
        step();                                    // accepting edge
        valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 1);
        step();
        chk("sync_accept_p1", 32'(sync), 1);
        step();
        chk("sync_accept_p2", 32'(sync), 0);
        capture(w, l, fl);
        chk("frame_word", 32'(w), 32'h32ABCD);
        chk("sync_low_cycles", 32'(l), 96);
        chk("sclk_falls", 32'(fl), 24);
        chk("sdin_idle", 32'(sdin), 0);
        chk("sclk_idle", 32'(sclk), 1);
        step(); step();
        chk("busy_clear", 32'(busy), 0);
        chk("no_err_valid", 32'(err), 0);

        // ---- five queued commands with valid held high ----
        fork
            begin
                int k;
                logic acc;
                for (k = 0; k < 5; k++) begin
                    valid = 1'b1;
                    {code, addr, data} = words[k];
                    for (int t = 0; t < 1000; t++) begin
                        acc = ready;
                        step();
                        if (acc) break;
                    end
                end
                valid = 1'b0;
                chk("ready_full", 32'(ready), 0);
            end
            begin
                int gh, gl, gf;
                logic [23:0] gw;
                for (int f = 0; f < 5; f++) begin
                    wait_low(gh);
                    if (f > 0) chk("sync_gap", 32'(gh), 4);
                    capture(gw, gl, gf);
                    chk("queued_word", 32'(gw), 32'(words[f]));
                end
            end
        join
        wait_idle();
        chk("ready_after_drain", 32'(ready), 1);

        // ---- bad address on the 4-channel instance ----
        addr4 = 4'h6; code4 = 4'h3; data4 = 16'h1234; v4 = 1'b1;
        step();
        v4 = 1'b0;
        chk("err_pulse", 32'(err4), 1);
        chk("err_busy", 32'(busy4), 0);
        step();
        chk("err_one_cycle", 32'(err4), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy4 || !sync4) bad = 1;
            step();
        end
        chk("no_frame_bad_addr", 32'(bad), 0);
        addr4 = 4'h4; v4 = 1'b1;
        step();
        v4 = 1'b0;
        chk("err_boundary", 32'(err4), 1);
        addr4 = 4'h3; v4 = 1'b1;
        step();
        v4 = 1'b0;
        chk("ok_last_addr_err", 32'(err4), 0);
        chk("ok_last_addr_busy", 32'(busy4), 1);
        for (int i = 0; i < 400 && busy4; i++) step();
        chk("dut4_idle", 32'(busy4), 0);

`ifdef DAC_LDAC_PULSE_EN
        // ---- LDAC pulse after two code-1 frames, none after code 3 ----
        begin
            int pulses, lowc, frames, frames_at;
            logic pl, ps;
            code = 4'h1; addr = 4'h0; data = 16'h0001; valid = 1'b1;
            step();
            addr = 4'h1;
            step();
            valid = 1'b0;
            pulses = 0; lowc = 0; frames = 0; frames_at = 0; pl = ldac; ps = sync;
            for (int i = 0; i < 600; i++) begin
                step();
                if (ps && !sync) frames++;
                if (pl && !ldac) begin
                    pulses++;
                    frames_at = frames;
                end
                if (!ldac) lowc++;
                pl = ldac; ps = sync;
            end
            chk("ldac_pulses", 32'(pulses), 1);
            chk("ldac_low_cycles", 32'(lowc), 4);
            chk("ldac_after_frame", 32'(frames_at), 2);
            code = 4'h3; valid = 1'b1;
            step();
            valid = 1'b0;
            lowc = 0;
            for (int i = 0; i < 300; i++) begin
                step();
                if (!ldac) lowc++;
            end
            chk("ldac_none_code3", 32'(lowc), 0);
        end
`endif

        // ---- reset at the 12th falling SCLK edge ----
        valid = 1'b1; code = 4'h3;
        addr = 4'h0; data = 16'h1111; step();
        addr = 4'h1; data = 16'h2222; step();
        addr = 4'h2; data = 16'h3333; step();
        valid = 1'b0;
        wait_low(h);
        chk("abort_frame_start", 32'(sync), 0);
        fl = 0;
        begin
            logic prev;
            prev = sclk;
            for (int i = 0; i < 200 && fl < 12; i++) begin
                step();
                if (prev && !sclk) fl++;
                prev = sclk;
            end
        end
        chk("abort_fall_count", 32'(fl), 12);
        rst = 1'b1;
        #1;
        chk("abort_sync", 32'(sync), 1);
        chk("abort_sclk", 32'(sclk), 1);
        chk("abort_sdin", 32'(sdin), 0);
        chk("abort_busy", 32'(busy), 0);
        step(); step();
        rst = 1'b0;
        step();
        chk("abort_ready", 32'(ready), 1);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (!sync || busy) bad = 1;
            step();
        end
        chk("abort_no_resume", 32'(bad), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
